// File: rtl/spi_link_pkg.sv
// Shared definitions for the 8-byte SPI memory-frame link.
// Used by both the responder (spi_slave_mem) and the initiator.
package spi_link_pkg;

    localparam int FRAME_BITS = 64;
    localparam int BYTE_W     = 8;
    localparam int ADDR_W     = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FULL
    } state_t;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchroniser with rise/fall detect on the synchronised level.
module spi_in_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign q    = chain[SYNC_STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_mem.sv
// SPI responder with an 8x8 register file, full-duplex read-back on miso.
// Define SPI_SLV_FRAME_ATOMIC_EN to commit whole frames only on frame_done.
module spi_slave_mem
    import spi_link_pkg::*;
#(
    parameter int NBYTES      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BYTE_W-1:0] rd_data,
    output logic              rx_valid,
    output logic [ADDR_W-1:0] rx_addr,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int BIT_W = $clog2(BYTE_W);
    localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(NBYTES - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(BYTE_W - 1);

    logic sclk_fall, cs_fall, cs_rise, mosi_s;
    logic unused_sclk_q, unused_sclk_rise, unused_cs_q;
    logic unused_mosi_rise, unused_mosi_fall;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .d(sclk),
        .q(unused_sclk_q), .rise(unused_sclk_rise), .fall(sclk_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst(rst), .d(cs_n),
        .q(unused_cs_q), .rise(cs_rise), .fall(cs_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .d(mosi),
        .q(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    state_t               state, state_next;
    logic [BIT_W-1:0]     bit_cnt;
    logic [ADDR_W-1:0]    byte_cnt;
    logic [BYTE_W-2:0]    shreg;
    logic                 overrun;
    byte_t                mem [NBYTES];
    byte_t                new_byte;
    logic                 byte_end;
`ifdef SPI_SLV_FRAME_ATOMIC_EN
    byte_t                shadow [NBYTES];
`endif

    assign new_byte = {mosi_s, shreg};
    assign byte_end = sclk_fall && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (cs_fall) state_next = ACTIVE;
            ACTIVE: begin
                if (cs_rise)
                    state_next = IDLE;
                else if (byte_end && byte_cnt == LAST_BYTE)
                    state_next = FULL;
            end
            FULL:    if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            shreg      <= '0;
            overrun    <= 1'b0;
            miso       <= 1'b0;
            rd_data    <= '0;
            rx_valid   <= 1'b0;
            rx_addr    <= '0;
            rx_byte    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            for (int i = 0; i < NBYTES; i++) begin
                mem[i] <= '0;
`ifdef SPI_SLV_FRAME_ATOMIC_EN
                shadow[i] <= '0;
`endif
            end
        end else begin
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            rd_data    <= mem[rd_addr];
            unique case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (cs_fall) begin
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        overrun  <= 1'b0;
                        miso     <= mem[0][0];
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        miso      <= 1'b0;
                    end else if (sclk_fall) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (byte_end) begin
`ifdef SPI_SLV_FRAME_ATOMIC_EN
                            shadow[byte_cnt] <= new_byte;
`else
                            mem[byte_cnt] <= new_byte;
`endif
                            rx_valid <= 1'b1;
                            rx_addr  <= byte_cnt;
                            rx_byte  <= new_byte;
                            byte_cnt <= byte_cnt + 1'b1;
                            // next byte is untouched by this commit: old data
                            if (byte_cnt == LAST_BYTE) miso <= 1'b0;
                            else miso <= mem[byte_cnt + 1'b1][0];
                        end else begin
                            shreg[bit_cnt] <= mosi_s;
                            miso <= mem[byte_cnt][bit_cnt + 1'b1];
                        end
                    end
                end
                FULL: begin
                    miso <= 1'b0;
                    if (cs_rise) begin
                        frame_done <= ~overrun;
                        frame_err  <= overrun;
`ifdef SPI_SLV_FRAME_ATOMIC_EN
                        if (!overrun)
                            for (int i = 0; i < NBYTES; i++)
                                mem[i] <= shadow[i];
`endif
                    end else if (sclk_fall) begin
                        overrun <= 1'b1;
                    end
                end
                default: miso <= 1'b0;
            endcase
        end
    end

endmodule
